// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm trigger block.
// Holds the FSM state enum, time-field widths and the match helper.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_e;

  localparam int HOUR_W       = 5;
  localparam int MIN_W        = 6;
  localparam int SEC_W        = 6;
  localparam int SECS_PER_MIN = 60;

  localparam int RING_W = 8;
  localparam int SNZ_W  = 12;
  localparam int SCNT_W = 2;

  // True on the exact top-of-minute second of the stored alarm time.
  function automatic logic time_hit(
    input logic [HOUR_W-1:0] ch,
    input logic [MIN_W-1:0]  cm,
    input logic [SEC_W-1:0]  cs,
    input logic [HOUR_W-1:0] ah,
    input logic [MIN_W-1:0]  am
  );
    return (ch == ah) && (cm == am) && (cs == '0);
  endfunction

endpackage

// File: rtl/alarm_trigger_button_edge.sv
// One-flop rising-edge detector for a synchronous button level.
// Ports: i_clk, i_rst_n (async low), i_btn level in, o_rise one-clk pulse.
module button_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_prev <= 1'b0;
    else          r_prev <= i_btn;
  end

  assign o_rise = i_btn & ~r_prev;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm trigger: compares alarm vs clock time, drives buzzer, snooze/stop.
// Ports: clk, rst (async low), sec_tick, cur_*, alarm_*, alarm_on,
//   set_alarm_en, snooze_button, stop_button -> o_buzzer, o_ringing,
//   o_snoozed, o_snooze_cnt. Macro BUZZER_BEEP_EN selects 1s beep pattern.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sec_tick,
  input  logic [HOUR_W-1:0] cur_hours,
  input  logic [MIN_W-1:0]  cur_minutes,
  input  logic [SEC_W-1:0]  cur_seconds,
  input  logic [HOUR_W-1:0] alarm_hours,
  input  logic [MIN_W-1:0]  alarm_minutes,
  input  logic              alarm_on,
  input  logic              set_alarm_en,
  input  logic              snooze_button,
  input  logic              stop_button,
  output logic              o_buzzer,
  output logic              o_ringing,
  output logic              o_snoozed,
  output logic [1:0]        o_snooze_cnt
);

  localparam logic [RING_W-1:0] RING_LAST =
    RING_W'(RING_SECS - 1);
  localparam logic [SNZ_W-1:0] SNZ_LAST =
    SNZ_W'(SNOOZE_MIN * SECS_PER_MIN - 1);
  localparam logic [SCNT_W-1:0] SCNT_MAX =
    SCNT_W'(MAX_SNOOZE);

  state_e r_state;
  state_e w_next;

  logic [RING_W-1:0] r_ring_cnt;
  logic [RING_W-1:0] w_ring_nxt;
  logic [SNZ_W-1:0]  r_snz_cnt;
  logic [SNZ_W-1:0]  w_snz_nxt;
  logic [SCNT_W-1:0] r_scnt;
  logic [SCNT_W-1:0] w_scnt_nxt;

  logic r_ringing;
  logic r_snoozed;

  logic w_snz_edge;
  logic w_stp_edge;
  logic w_enabled;
  logic w_match;

  button_edge u_snz_edge (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_btn   (snooze_button),
    .o_rise  (w_snz_edge)
  );

  button_edge u_stp_edge (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_btn   (stop_button),
    .o_rise  (w_stp_edge)
  );

  assign w_enabled = alarm_on & ~set_alarm_en;

  assign w_match = w_enabled & sec_tick &
    time_hit(cur_hours, cur_minutes, cur_seconds,
             alarm_hours, alarm_minutes);

  always_comb begin
    w_next     = r_state;
    w_ring_nxt = r_ring_cnt;
    w_snz_nxt  = r_snz_cnt;
    w_scnt_nxt = r_scnt;
    if (!w_enabled) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_match) begin
            w_next     = RINGING;
            w_ring_nxt = '0;
            w_scnt_nxt = '0;
          end
        end
        RINGING: begin
          if (w_stp_edge) begin
            w_next = IDLE;
          end else if (w_snz_edge) begin
            // Snooze past the budget behaves as stop.
            if (r_scnt < SCNT_MAX) begin
              w_next     = SNOOZE;
              w_snz_nxt  = '0;
              w_scnt_nxt = r_scnt + 1'b1;
            end else begin
              w_next = IDLE;
            end
          end else if (sec_tick) begin
            if (r_ring_cnt == RING_LAST) w_next = IDLE;
            else w_ring_nxt = r_ring_cnt + 1'b1;
          end
        end
        SNOOZE: begin
          if (w_stp_edge) begin
            w_next = IDLE;
          end else if (sec_tick) begin
            if (r_snz_cnt == SNZ_LAST) begin
              w_next     = RINGING;
              w_ring_nxt = '0;
            end else begin
              w_snz_nxt = r_snz_cnt + 1'b1;
            end
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
      r_scnt     <= '0;
      r_ringing  <= 1'b0;
      r_snoozed  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ring_cnt <= w_ring_nxt;
      r_snz_cnt  <= w_snz_nxt;
      r_scnt     <= w_scnt_nxt;
      r_ringing  <= (w_next == RINGING);
      r_snoozed  <= (w_next == SNOOZE);
    end
  end

`ifdef BUZZER_BEEP_EN
  logic r_beep;

  // Starts on at ring entry, then flips once per second.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beep <= 1'b0;
    end else if (w_next != RINGING) begin
      r_beep <= 1'b0;
    end else if (r_state != RINGING) begin
      r_beep <= 1'b1;
    end else if (sec_tick) begin
      r_beep <= ~r_beep;
    end
  end

  assign o_buzzer = r_beep;
`else
  assign o_buzzer = r_ringing;
`endif

  assign o_ringing    = r_ringing;
  assign o_snoozed    = r_snoozed;
  assign o_snooze_cnt = r_scnt;

endmodule

// File: doc/alarm_trigger.md
Name: alarm_trigger

Overview:
Downstream consumer of set_alarm. Compares the stored alarm time (hours/minutes plus the on/off flag from set_alarm) against the running clock time and drives the buzzer. Supports snooze with a bounded snooze count, stop, and ring timeout. Sits between set_alarm / the timekeeping counter and the buzzer/LED output pins.

Parameters:
RING_SECS, 60, seconds the buzzer rings before auto-stop (1..255)
SNOOZE_MIN, 5, snooze length in minutes (1..59)
MAX_SNOOZE, 3, snoozes allowed per alarm event; the next snooze press acts as stop

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
sec_tick  input  1  one-clk pulse once per second from the timekeeper
cur_hours  input  5  current hours, 0..23
cur_minutes  input  6  current minutes, 0..59
cur_seconds  input  6  current seconds, 0..59
alarm_hours  input  5  o_hours from set_alarm
alarm_minutes  input  6  o_minutes from set_alarm
alarm_on  input  1  on_off_alarm from set_alarm
set_alarm_en  input  1  alarm being edited; suppresses triggering
snooze_button  input  1  synchronous level, high while pressed
stop_button  input  1  synchronous level, high while pressed
o_buzzer  output  1  buzzer drive
o_ringing  output  1  high in RINGING
o_snoozed  output  1  high in SNOOZE
o_snooze_cnt  output  2  snoozes used in the current event

Behaviour:
- Reset (rst=0, async): state IDLE. o_buzzer, o_ringing, o_snoozed, o_snooze_cnt, and all counters are 0. Button edge registers are cleared to 0.
- Buttons: rising-edge detected internally (one registered copy each). Holding a button acts once.
- match = alarm_on & ~set_alarm_en & sec_tick & (cur_hours==alarm_hours) & (cur_minutes==alarm_minutes) & (cur_seconds==0).
- IDLE:
  - On match → RINGING on the next clk. The ring counter loads 0 and o_snooze_cnt loads 0.
- RINGING:
  - o_ringing=1.
  - The ring counter increments on each sec_tick.
  - Stop edge → IDLE.
  - Snooze edge with o_snooze_cnt<MAX_SNOOZE → SNOOZE. The snooze counter loads 0 and o_snooze_cnt increments.
  - Snooze edge with o_snooze_cnt==MAX_SNOOZE → IDLE.
  - Ring counter reaching RING_SECS-1 while sec_tick=1 → IDLE.
- SNOOZE:
  - o_snoozed=1 and o_buzzer=0.
  - The snooze counter (12 bit) increments on each sec_tick.
  - Snooze counter reaching SNOOZE_MIN*60-1 while sec_tick=1 → RINGING, with the ring counter reloaded to 0.
  - Stop edge → IDLE.
- Priority in any state: (1) alarm_on=0 or set_alarm_en=1 → IDLE; (2) stop edge; (3) snooze edge; (4) timeout.
  - Stop and snooze on the same clk: stop wins.
  - Timeout and a button on the same clk: the button wins.
- Latency: all state changes take effect one clk after the qualifying input. Outputs are registered.
- A match while in RINGING or SNOOZE is ignored; no restart.
- o_snooze_cnt holds its value in IDLE until the next trigger.
- Alarm time 00:00 triggers correctly when cur_* wraps from 23:59:59 to 00:00:00.

Optional Feature:
BUZZER_BEEP_EN
- Defined: in RINGING, o_buzzer toggles on every sec_tick, giving a 1 s on / 1 s off pattern. It starts at 1 on entry to RINGING.
- Undefined: o_buzzer = o_ringing (solid tone).
- In both cases o_buzzer is 0 outside RINGING.

Decomposition:
- Package alarm_pkg:
  - State enum (IDLE, RINGING, SNOOZE).
  - Width constants HOUR_W=5, MIN_W=6, SEC_W=6.
  - SECS_PER_MIN=60.
- Sub-module button_edge: a one-flop rising-edge detector, reset to 0 and instantiated twice (snooze, stop).

Test Plan:
- Alarm 07:30, alarm_on=1, time goes 07:29:59 → 07:30:00 with sec_tick → o_ringing=1 and o_buzzer=1 one clk later.
- Ringing with RING_SECS=60 and no buttons → o_ringing=0 after the 60th sec_tick.
- Snooze edge while ringing → o_snoozed=1, o_snooze_cnt=1, o_buzzer=0. After 300 sec_ticks → RINGING again.
- Snooze pressed 3 times (MAX_SNOOZE=3), then a 4th snooze edge in RINGING → IDLE, o_snooze_cnt=3.
- stop_button and snooze_button rising on the same clk while RINGING → IDLE, o_snooze_cnt unchanged.
- rst=0 asserted mid-RINGING, between clk edges → all outputs 0 immediately. Match with alarm_on=0 or set_alarm_en=1 → stays IDLE.
